// File: rtl/multicycle_alu_if.sv
// Operation bus for multicycle_alu: request side driven by the controller,
// result/flag side driven by the ALU, plus the ALU's FSM state for observation.
interface multicycle_alu_if #(parameter int WIDTH = 32);
  // start is sampled only while the ALU is idle; a start seen while busy or
  // during done is dropped. done pulses for one cycle with all results valid,
  // and results/flags then hold until the next done.
  logic             start;
  logic [3:0]       opcode;
  logic             mul_sel;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             set_cond_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUresult;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;
  logic             set_cond_bit;
  logic             result_write;
  logic [1:0]       state_dbg;

  modport slave (
    input  start, opcode, mul_sel, operand_a, operand_b, set_cond_in,
    output busy, done, ALUresult, zero, negative, carry, overflow,
           set_cond_bit, result_write, state_dbg
  );

  modport master (
    output start, opcode, mul_sel, operand_a, operand_b, set_cond_in,
    input  busy, done, ALUresult, zero, negative, carry, overflow,
           set_cond_bit, result_write, state_dbg
  );
endinterface

// File: rtl/multicycle_alu.sv
// Multicycle ARM-style ALU: single-cycle data-processing ops and an iterative
// shift-add multiplier, with registered result and NZCV-style flags.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input logic           clock,
  input logic           reset,
  multicycle_alu_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2, DONE = 2'd3} state_t;
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    mul_cnt;
  logic [WIDTH-1:0] a_q, b_q, acc, mcand, mplier;
  logic [3:0]       op_q;
  logic             mul_q, s_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, neg_q, carry_q, ovf_q, scb_q, rw_q;
  logic [WIDTH-1:0] alu_res, add_x, add_y;
  logic             add_cin, is_arith, is_cmp, res_v;
  logic [WIDTH:0]   sum;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = bus.mul_sel ? MUL : EXEC;
      EXEC:    state_nxt = DONE;
      MUL:     if (mul_cnt == CW'(WIDTH)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subtract-type ops are folded into one adder as x + ~y + cin.
  always_comb begin
    alu_res  = '0;
    add_x    = a_q;
    add_y    = b_q;
    add_cin  = 1'b0;
    is_arith = 1'b0;
    case (op_q)
      4'b0000, 4'b1000: alu_res = a_q & b_q;
      4'b0001, 4'b1001: alu_res = a_q ^ b_q;
      4'b0010, 4'b1010: begin is_arith = 1'b1; add_y = ~b_q; add_cin = 1'b1; end
      4'b0011:          begin is_arith = 1'b1; add_x = b_q; add_y = ~a_q; add_cin = 1'b1; end
      4'b0100, 4'b1011: is_arith = 1'b1;
      4'b0101:          begin is_arith = 1'b1; add_cin = carry_q; end
      4'b0110:          begin is_arith = 1'b1; add_y = ~b_q; add_cin = carry_q; end
      4'b0111:          begin is_arith = 1'b1; add_x = b_q; add_y = ~a_q; add_cin = carry_q; end
      4'b1100:          alu_res = a_q | b_q;
      4'b1101:          alu_res = b_q;
      4'b1110:          alu_res = a_q & ~b_q;
      default:          alu_res = ~b_q;
    endcase
    if (is_arith) alu_res = sum[WIDTH-1:0];
  end

  assign sum    = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  assign res_v  = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
  assign is_cmp = !mul_q && (op_q[3:2] == 2'b10);

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q <= '0; b_q <= '0; op_q <= '0; mul_q <= 1'b0; s_q <= 1'b0;
      acc <= '0; mcand <= '0; mplier <= '0; mul_cnt <= '0;
      result_q <= '0; zero_q <= 1'b1; neg_q <= 1'b0;
      carry_q <= 1'b0; ovf_q <= 1'b0; scb_q <= 1'b0; rw_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_q     <= bus.operand_a;
          b_q     <= bus.operand_b;
          op_q    <= bus.opcode;
          mul_q   <= bus.mul_sel;
          s_q     <= bus.set_cond_in;
          acc     <= '0;
          mcand   <= bus.operand_a;
          mplier  <= bus.operand_b;
          mul_cnt <= '0;
        end
        EXEC: begin
          result_q <= alu_res;
          zero_q   <= (alu_res == '0);
          neg_q    <= alu_res[WIDTH-1];
          if (is_arith) begin
            carry_q <= sum[WIDTH];
            ovf_q   <= res_v;
          end
          scb_q <= s_q | is_cmp;
          rw_q  <= !is_cmp;
        end
        MUL: begin
          // WIDTH shift-add steps, then one cycle to publish the product.
          if (mul_cnt == CW'(WIDTH)) begin
            result_q <= acc;
            zero_q   <= (acc == '0);
            neg_q    <= acc[WIDTH-1];
            scb_q    <= s_q;
            rw_q     <= 1'b1;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            mul_cnt <= mul_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state == EXEC) || (state == MUL);
  assign bus.done         = (state == DONE);
  assign bus.ALUresult    = result_q;
  assign bus.zero         = zero_q;
  assign bus.negative     = neg_q;
  assign bus.carry        = carry_q;
  assign bus.overflow     = ovf_q;
  assign bus.set_cond_bit = scb_q;
  assign bus.result_write = rw_q;
  assign bus.state_dbg    = state;
endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: a reference model pushes expected
// result/flag vectors into a queue, popped when done is seen.
module tb_multicycle_alu;
  localparam int W  = 32;
  localparam int EW = W + 6;

  logic clock = 1'b0;
  logic reset = 1'b1;

  multicycle_alu_if #(.WIDTH(W)) bus();
  multicycle_alu #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  always #5 clock = ~clock;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs, exp_v;
  int total = 0;
  int bad = 0;
  int obs_lat, obs_busy;
  logic m_c = 1'b0;
  logic m_v = 1'b0;

  function automatic logic [EW-1:0] sample();
    return {bus.ALUresult, bus.zero, bus.negative, bus.carry, bus.overflow,
            bus.set_cond_bit, bus.result_write};
  endfunction

  // Model one operation, queue its expected outputs, drive it and wait for done.
  // Inputs are scrambled after the accepting edge; poke_at re-asserts start once.
  task automatic do_op(input logic [3:0] op, input logic mul, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic s, input int poke_at);
    logic [W-1:0] r;
    logic [W:0] t;
    logic c, v, cmp;
    bit got;
    c = m_c; v = m_v; r = '0;
    cmp = !mul && (op[3:2] == 2'b10);
    if (mul) r = a * b;
    else begin
      case (op)
        4'd0, 4'd8:  r = a & b;
        4'd1, 4'd9:  r = a ^ b;
        4'd2, 4'd10: begin r = a - b; c = (a >= b); v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
        4'd3:        begin r = b - a; c = (b >= a); v = (b[W-1] != a[W-1]) && (r[W-1] != b[W-1]); end
        4'd4, 4'd11: begin {c, r} = {1'b0, a} + {1'b0, b}; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
        4'd5:        begin {c, r} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, m_c}; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
        4'd6:        begin
          r = a - b - {{(W-1){1'b0}}, ~m_c};
          t = {1'b0, b} + {{W{1'b0}}, ~m_c};
          c = ({1'b0, a} >= t);
          v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end
        4'd7:        begin
          r = b - a - {{(W-1){1'b0}}, ~m_c};
          t = {1'b0, a} + {{W{1'b0}}, ~m_c};
          c = ({1'b0, b} >= t);
          v = (b[W-1] != a[W-1]) && (r[W-1] != b[W-1]);
        end
        4'd12:       r = a | b;
        4'd13:       r = b;
        4'd14:       r = a & ~b;
        default:     r = ~b;
      endcase
    end
    m_c = c; m_v = v;
    exp_q.push_back({r, (r == '0), r[W-1], c, v, s | cmp, !cmp});

    @(posedge clock); #1;
    bus.opcode = op; bus.mul_sel = mul; bus.operand_a = a; bus.operand_b = b;
    bus.set_cond_in = s; bus.start = 1'b1;
    obs_lat = 0; obs_busy = 0; got = 0;
    while (!got && obs_lat < 200) begin
      @(posedge clock); #1;
      obs_lat++;
      if (bus.busy) obs_busy++;
      if (bus.done) got = 1;
      bus.start = !got && (obs_lat == poke_at);
      bus.opcode = 4'($urandom_range(0, 15));
      bus.mul_sel = 1'($urandom_range(0, 1));
      bus.operand_a = $urandom; bus.operand_b = $urandom;
      bus.set_cond_in = 1'($urandom_range(0, 1));
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL done_timeout: op=%h mul=%b no done after %0d cycles, required done", op, mul, obs_lat);
    end
    obs = sample();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.opcode = '0; bus.mul_sel = 1'b0;
    bus.operand_a = '0; bus.operand_b = '0; bus.set_cond_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (sample() !== {{W{1'b0}}, 6'b100000}) begin
      bad++; $display("FAIL reset_outputs: got %h required %h", sample(), {{W{1'b0}}, 6'b100000});
    end
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++; $display("FAIL reset_busy_done: got %b required 00", {bus.busy, bus.done});
    end
    reset = 1'b0;
    m_c = 1'b0; m_v = 1'b0;
  endtask

  task automatic test_add();
    do_op(4'b0100, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b1, 0);
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v || obs !== {32'h8000_0000, 6'b010111}) begin
      bad++; $display("FAIL add_overflow: got %h required %h", obs, exp_v);
    end
    total++;
    if (obs_lat !== 2) begin
      bad++; $display("FAIL add_latency: got %0d required 2", obs_lat);
    end
    @(posedge clock); #1;
    total++;
    if (bus.done !== 1'b0) begin
      bad++; $display("FAIL done_one_cycle: done=%b required 0", bus.done);
    end
  endtask

  task automatic test_cmp();
    do_op(4'b1010, 1'b0, 32'd5, 32'd5, 1'b0, 0);
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v || obs !== {32'h0, 6'b101010}) begin
      bad++; $display("FAIL cmp_equal: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_wrap_adc();
    do_op(4'b0100, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b1, 0);
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v || obs !== {32'h0, 6'b101011}) begin
      bad++; $display("FAIL add_wrap: got %h required %h", obs, exp_v);
    end
    do_op(4'b0101, 1'b0, 32'h1, 32'h1, 1'b1, 0);
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v || obs !== {32'h3, 6'b000011}) begin
      bad++; $display("FAIL adc_carry_in: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_mul();
    do_op(4'b0100, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, 0);
    void'(exp_q.pop_front());
    do_op(4'b0000, 1'b1, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 0);
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v || obs !== {32'hFFFF_FFFF, 6'b011001}) begin
      bad++; $display("FAIL mul_result: got %h required %h", obs, exp_v);
    end
    total++;
    if (obs_lat !== W + 2 || obs_busy !== W + 1) begin
      bad++; $display("FAIL mul_timing: latency %0d busy %0d required %0d/%0d", obs_lat, obs_busy, W + 2, W + 1);
    end
  endtask

  task automatic test_start_while_busy();
    int dones;
    do_op(4'b0000, 1'b1, 32'd1234, 32'd5678, 1'b1, 6);
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin
      bad++; $display("FAIL busy_start_result: got %h required %h", obs, exp_v);
    end
    dones = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (bus.done || bus.busy) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++; $display("FAIL busy_start_queued: extra busy/done cycles %0d required 0", dones);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    @(posedge clock); #1;
    bus.opcode = 4'd0; bus.mul_sel = 1'b1; bus.operand_a = 32'd77;
    bus.operand_b = 32'd99; bus.set_cond_in = 1'b1; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    m_c = 1'b0; m_v = 1'b0;
    total++;
    if ({bus.busy, bus.done, sample()} !== {2'b00, {W{1'b0}}, 6'b100000}) begin
      bad++; $display("FAIL abort_state: busy=%b done=%b out=%h required reset values", bus.busy, bus.done, sample());
    end
    dones = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (bus.done) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++; $display("FAIL abort_done: done pulses %0d required 0", dones);
    end
    do_op(4'b0100, 1'b0, 32'd2, 32'd3, 1'b0, 0);
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v || obs_lat !== 2 || obs[EW-1:6] !== 32'd5) begin
      bad++; $display("FAIL abort_then_add: got %h lat %0d required %h lat 2", obs, obs_lat, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    do_op(4'b1100, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0, 0);
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin
      bad++; $display("FAIL b2b_first: got %h required %h", obs, exp_v);
    end
    // start held during the done cycle must not be accepted
    bus.start = 1'b1; bus.mul_sel = 1'b0; bus.opcode = 4'd4;
    @(posedge clock); #1;
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.state_dbg !== 2'd0) begin
      bad++; $display("FAIL start_in_done: busy=%b state=%0d required busy=0 idle", bus.busy, bus.state_dbg);
    end
    do_op(4'b1110, 1'b0, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b1, 0);
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin
      bad++; $display("FAIL b2b_second: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_random_ops();
    logic [W-1:0] a, b;
    logic [3:0] op;
    logic mul;
    for (int i = 0; i < 16; i++) begin
      op  = 4'($urandom_range(0, 15));
      mul = (i % 6 == 5);
      a   = (i % 3 == 0) ? W'($urandom_range(0, 3)) : $urandom;
      b   = (i % 4 == 1) ? a : $urandom;
      do_op(op, mul, a, b, 1'($urandom_range(0, 1)), 0);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v || obs_lat !== (mul ? W + 2 : 2)) begin
        bad++; $display("FAIL rand_%0d op=%h mul=%b: got %h lat %0d required %h", i, op, mul, obs, obs_lat, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp();
    test_wrap_adc();
    test_mul();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    test_random_ops();
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
